// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg -- shared types for the button event controller.
//   CODE_W       : width of the event code carried on evt_code
//   evt_code_t   : PRESS / RELEASE / LONG / REPEAT
//   chan_state_t : per-channel FSM state (IDLE / DOWN / HELD)
package btn_evt_pkg;

  localparam int CODE_W = 2;

  typedef enum logic [CODE_W-1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } evt_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2
  } chan_state_t;

endpackage

// File: rtl/btn_evt_chan.sv
// btn_evt_chan -- one button channel: press/hold FSM, 32-bit hold counter,
// single pending-event slot and sticky overflow flag.
//   clk, reset          : clock, async active-high reset
//   db_level, db_tick   : debounced level / one-cycle press pulse
//   grant               : arbiter drains the slot this cycle
//   ovf_clr             : clear overflow flag (a simultaneous overflow wins)
//   slot_vld, slot_code : pending event presented to the arbiter
//   ovf                 : sticky event-lost flag
// Macro BTN_REPEAT_EN enables REPEAT events while HELD.
module btn_evt_chan
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              db_level,
  input  logic              db_tick,
  input  logic              grant,
  input  logic              ovf_clr,
  output logic              slot_vld,
  output logic [CODE_W-1:0] slot_code,
  output logic              ovf
);

`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam logic [31:0] LONG_M1 = 32'(LONG_CYC - 1);
  localparam logic [31:0] REP_M1  = 32'(REPEAT_CYC - 1);

  chan_state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        slot_vld_q, slot_vld_d;
  evt_code_t   slot_code_q, slot_code_d;
  logic        ovf_q, ovf_d;

  logic        post;
  evt_code_t   post_code;

  // State register (FSM, counter, slot, overflow)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_vld_q  <= 1'b0;
      slot_code_q <= PRESS;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_vld_q  <= slot_vld_d;
      slot_code_q <= slot_code_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next state / counter. A falling level is tested before any threshold
  // so release always beats LONG/REPEAT in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (db_tick) begin
        state_d = DOWN;
        cnt_d   = '0;
      end
      DOWN: begin
        if (!db_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_M1) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
      HELD: begin
        if (!db_level) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REP_EN) begin
          cnt_d = (cnt_q == REP_M1) ? '0 : cnt_q + 32'd1;
        end
        // without repeat the counter stays frozen at 0 (cleared on LONG)
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Event posting
  always_comb begin
    post      = 1'b0;
    post_code = PRESS;
    case (state_q)
      IDLE: if (db_tick) post = 1'b1;
      DOWN: begin
        if (!db_level) begin
          post = 1'b1; post_code = RELEASE;
        end else if (cnt_q == LONG_M1) begin
          post = 1'b1; post_code = LONG;
        end
      end
      HELD: begin
        if (!db_level) begin
          post = 1'b1; post_code = RELEASE;
        end else if (REP_EN && cnt_q == REP_M1) begin
          post = 1'b1; post_code = REPEAT;
        end
      end
      default: ;
    endcase
  end

  // Pending slot: a post overwrites; overflow only when the old event is
  // still there and not being drained this cycle.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_code_d = slot_code_q;
    ovf_d       = ovf_q;
    if (grant) slot_vld_d = 1'b0;
    if (post) begin
      slot_vld_d  = 1'b1;
      slot_code_d = post_code;
    end
    if (ovf_clr) ovf_d = 1'b0;
    if (post && slot_vld_q && !grant) ovf_d = 1'b1;
  end

  assign slot_vld  = slot_vld_q;
  assign slot_code = slot_code_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl -- turns debounced button activity on NCH channels into a
// single valid/ready stream of {channel, code} events.
//   clk, reset          : clock, async active-high reset
//   db_level, db_tick   : per-channel debounced level / press pulse
//   evt_valid/evt_ready : output handshake
//   evt_chan, evt_code  : event source and code (PRESS/RELEASE/LONG/REPEAT)
//   ovf_clr, ovf        : clear / sticky per-channel event-lost flags
// Macro BTN_REPEAT_EN enables REPEAT events (handled in btn_evt_chan).
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int LONG_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         db_level,
  input  logic [NCH-1:0]         db_tick,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [$clog2(NCH)-1:0] evt_chan,
  output logic [1:0]             evt_code,
  input  logic                   ovf_clr,
  output logic [NCH-1:0]         ovf
);

  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]             slot_vld;
  logic [NCH-1:0]             grant;
  logic [NCH-1:0][CODE_W-1:0] slot_code;

  logic              out_vld_q, out_vld_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    btn_evt_chan #(
      .LONG_CYC  (LONG_CYC),
      .REPEAT_CYC(REPEAT_CYC)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .db_level (db_level[g]),
      .db_tick  (db_tick[g]),
      .grant    (grant[g]),
      .ovf_clr  (ovf_clr),
      .slot_vld (slot_vld[g]),
      .slot_code(slot_code[g]),
      .ovf      (ovf[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      chan_q    <= '0;
      code_q    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      chan_q    <= chan_d;
      code_q    <= code_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Round-robin pick starting at rr_ptr. The output register reloads when
  // empty or on a handshake, so a grant can happen every cycle.
  always_comb begin
    logic          load_en;
    logic          pick_vld;
    logic [CW-1:0] pick_idx;
    logic [CW-1:0] idx;
    load_en   = !out_vld_q || evt_ready;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    idx       = '0;
    grant     = '0;
    out_vld_d = out_vld_q;
    chan_d    = chan_q;
    code_d    = code_q;
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'((int'(rr_ptr_q) + i) % NCH);
      if (!pick_vld && slot_vld[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
    if (load_en) begin
      out_vld_d = pick_vld;
      if (pick_vld) begin
        grant[pick_idx] = 1'b1;
        chan_d   = pick_idx;
        code_d   = slot_code[pick_idx];
        rr_ptr_d = (int'(pick_idx) == NCH - 1) ? '0 : pick_idx + CW'(1);
      end
    end
  end

  assign evt_valid = out_vld_q;
  assign evt_chan  = chan_q;
  assign evt_code  = code_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] db_level = '0;
  logic [3:0] db_tick = '0;
  logic       evt_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_chan;
  logic [1:0] evt_code;
  logic [3:0] ovf;

  btn_event_ctrl #(.NCH(4), .LONG_CYC(8), .REPEAT_CYC(4)) dut (
    .clk(clk), .reset(reset), .db_level(db_level), .db_tick(db_tick),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
    .evt_code(evt_code), .ovf_clr(ovf_clr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] tick;
    logic       rdy;
    logic       clr;
    logic       xv;
    logic [1:0] xch;
    logic [1:0] xcode;
    logic [3:0] xovf;
  } vec_t;
  vec_t vt[20];

  typedef struct { int ch; int code; int c; } evt_t;
  evt_t q[$];

  // delivered events, sampled mid-cycle
  always @(negedge clk)
    if (!reset && evt_valid && evt_ready)
      q.push_back('{int'(evt_chan), int'(evt_code), cyc});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input string nm, input int ch, input int code, input int c);
    evt_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: no event, want ch%0d code%0d @%0d", nm, ch, code, c);
    end else begin
      e = q.pop_front();
      if (e.ch != ch || e.code != code || e.c != c) begin
        errors++;
        $display("FAIL %s: got ch%0d code%0d @%0d want ch%0d code%0d @%0d",
                 nm, e.ch, e.code, e.c, ch, code, c);
      end
    end
  endtask

  task automatic expect_empty(input string nm);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d extra events, first code%0d ch%0d @%0d",
               nm, q.size(), q[0].code, q[0].ch, q[0].c);
      q.delete();
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; db_level = '0; db_tick = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    step(2);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    reset = 1'b0;
    step(2);
    q.delete();
  endtask

  int t, u, s;

  initial begin
    // ---- short press as a per-cycle vector table
    for (int i = 0; i < 20; i++)
      vt[i] = '{lvl:4'h0, tick:4'h0, rdy:1'b1, clr:1'b0, xv:1'b0, xch:2'd0, xcode:2'd0, xovf:4'h0};
    vt[10].tick = 4'b0001;
    for (int i = 11; i <= 14; i++) vt[i].lvl = 4'b0001;
    vt[12].xv = 1'b1; vt[12].xcode = PRESS;
    vt[17].xv = 1'b1; vt[17].xcode = RELEASE;

    step(3);
    chk("reset_valid", 32'(evt_valid), 0);
    chk("reset_chan", 32'(evt_chan), 0);
    chk("reset_code", 32'(evt_code), 0);
    chk("reset_ovf", 32'(ovf), 0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vt[i].xv));
      if (vt[i].xv) begin
        chk($sformatf("vec%0d_chan", i), 32'(evt_chan), 32'(vt[i].xch));
        chk($sformatf("vec%0d_code", i), 32'(evt_code), 32'(vt[i].xcode));
      end
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].xovf));
      db_level = vt[i].lvl; db_tick = vt[i].tick;
      evt_ready = vt[i].rdy; ovf_clr = vt[i].clr;
      step();
    end
    q.delete();

    // ---- long press on ch2, held 20 cycles
    do_reset();
    t = cyc;
    db_tick[2] = 1'b1; step(); db_tick[2] = 1'b0;
    db_level[2] = 1'b1; step(20);
    db_level[2] = 1'b0; step(6);
    expect_evt("long_press", 2, PRESS, t + 2);
    expect_evt("long_long", 2, LONG, t + 10);
`ifdef BTN_REPEAT_EN
    expect_evt("long_rep1", 2, REPEAT, t + 14);
    expect_evt("long_rep2", 2, REPEAT, t + 18);
    expect_evt("long_rep3", 2, REPEAT, t + 22);
`endif
    expect_evt("long_release", 2, RELEASE, t + 23);
    expect_empty("long_tail");

    // ---- round robin: ch1 event moves rr_ptr to 2, then ch1+ch3 together
    do_reset();
    t = cyc;
    db_tick[1] = 1'b1; step(); db_tick[1] = 1'b0; step(6);
    expect_evt("rr_pre_press", 1, PRESS, t + 2);
    expect_evt("rr_pre_rel", 1, RELEASE, t + 3);
    u = cyc;
    db_tick = 4'b1010; step(); db_tick = '0;
    db_level = 4'b1010; step(2);
    db_level = '0; step(6);
    expect_evt("rr_p3", 3, PRESS, u + 2);
    expect_evt("rr_p1", 1, PRESS, u + 3);
    expect_evt("rr_r3", 3, RELEASE, u + 5);
    expect_evt("rr_r1", 1, RELEASE, u + 6);
    expect_empty("rr_tail");

    // ---- backpressure: PRESS stuck in output, LONG overwritten by RELEASE
    do_reset();
    evt_ready = 1'b0;
    t = cyc;
    db_tick[0] = 1'b1; step(); db_tick[0] = 1'b0;
    for (int k = 1; k < 30; k++) begin
      db_level[0] = (k <= 11);
      if (k >= 2) begin
        chk($sformatf("bp_valid_k%0d", k), 32'(evt_valid), 1);
        chk($sformatf("bp_chan_k%0d", k), 32'(evt_chan), 0);
        chk($sformatf("bp_code_k%0d", k), 32'(evt_code), 32'(PRESS));
      end
      if (k == 12) chk("bp_ovf_before", 32'(ovf), 0);
      if (k == 16) chk("bp_ovf_set", 32'(ovf), 1);
      step();
    end
    evt_ready = 1'b1;
    s = cyc;
    step(4);
    expect_evt("bp_press", 0, PRESS, s);
    expect_evt("bp_release", 0, RELEASE, s + 1);
    expect_empty("bp_tail");
    chk("bp_ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("bp_ovf_clr", 32'(ovf), 0);

    // ---- release on the same cycle the LONG threshold is reached
    do_reset();
    t = cyc;
    db_tick[1] = 1'b1; step(); db_tick[1] = 1'b0;
    db_level[1] = 1'b1; step(7);
    db_level[1] = 1'b0; step(8);
    expect_evt("tie_press", 1, PRESS, t + 2);
    expect_evt("tie_release", 1, RELEASE, t + 10);
    expect_empty("tie_tail");

    // ---- reset in the middle of a hold
    do_reset();
    evt_ready = 1'b0;
    db_tick[2] = 1'b1; step(); db_tick[2] = 1'b0;
    db_level[2] = 1'b1; step(2);
    chk("rmh_valid_pre", 32'(evt_valid), 1);
    reset = 1'b1; #2;
    chk("rmh_valid_rst", 32'(evt_valid), 0);
    chk("rmh_code_rst", 32'(evt_code), 0);
    step();
    db_level[2] = 1'b0; reset = 1'b0; evt_ready = 1'b1;
    step(10);
    expect_empty("rmh_no_release");
    t = cyc;
    db_tick[2] = 1'b1; step(); db_tick[2] = 1'b0; step(4);
    expect_evt("rmh_idle_press", 2, PRESS, t + 2);
    expect_evt("rmh_idle_rel", 2, RELEASE, t + 3);
    expect_empty("rmh_tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
